// File: rtl/fp12_acc_if.sv
// Handshake bundle between an FP12 product source and fp12_accumulator.
// Carries sum_flags only when FP12_ACC_STICKY_FLAGS_EN is defined.
interface fp12_acc_if #(
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [11:0]      in_data;
   logic             in_last;
   logic             sum_valid;
   logic             sum_ready;
   logic [11:0]      sum_data;
   logic [CNT_W-1:0] sum_count;
`ifdef FP12_ACC_STICKY_FLAGS_EN
   logic [1:0]       sum_flags;

   modport master (output in_valid, in_data, in_last, sum_ready,
                   input  in_ready, sum_valid, sum_data, sum_count, sum_flags);
   modport slave  (input  in_valid, in_data, in_last, sum_ready,
                   output in_ready, sum_valid, sum_data, sum_count, sum_flags);
`else
   modport master (output in_valid, in_data, in_last, sum_ready,
                   input  in_ready, sum_valid, sum_data, sum_count);
   modport slave  (input  in_valid, in_data, in_last, sum_ready,
                   output in_ready, sum_valid, sum_data, sum_count);
`endif
endinterface

// File: rtl/fp12_accumulator.sv
// FP12 (1/5/6, bias 15) running-sum accumulator: ACCEPT -> ALIGN -> NORM (-> HOLD).
// Optional FP12_ACC_STICKY_FLAGS_EN adds sticky {ovf, unf} flags on sum_flags.
module fp12_accumulator #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned ALIGN_DROP = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   fp12_acc_if.slave  acc_if
);
   typedef enum logic [1:0] {ACCEPT, ALIGN, NORM, HOLD} state_t;

   localparam logic [4:0] DROP_L = ALIGN_DROP[4:0];

   state_t           state_q, state_d;
   logic [11:0]      term_q, acc_q, sum_data_q;
   logic             last_q;
   logic             sa_q, sb_q;
   logic [9:0]       ma_q, mb_q;
   logic [4:0]       exp_q;
   logic [CNT_W-1:0] cnt_q, sum_count_q, cnt_inc;

   logic [4:0]        ea, eb, diff, big_exp;
   logic [9:0]        man_a, man_b, al_a, al_b;
   logic [10:0]       mag;
   logic              sgn;
   logic [3:0]        lz;
   logic [9:0]        nm;
   logic signed [6:0] ne;
   logic [11:0]       res;
`ifdef FP12_ACC_STICKY_FLAGS_EN
   logic              ovf_w, unf_w, ovf_q, unf_q;
`endif

   // Alignment: the smaller-exponent operand is shifted right, or dropped entirely.
   always_comb begin
      ea      = acc_q[10:6];
      eb      = term_q[10:6];
      man_a   = (ea != '0) ? {1'b1, acc_q[5:0], 3'b000}  : '0;
      man_b   = (eb != '0) ? {1'b1, term_q[5:0], 3'b000} : '0;
      al_a    = man_a;
      al_b    = man_b;
      if (ea >= eb) begin
         diff    = ea - eb;
         big_exp = ea;
         al_b    = (diff >= DROP_L) ? '0 : man_b >> diff;
      end else begin
         diff    = eb - ea;
         big_exp = eb;
         al_a    = (diff >= DROP_L) ? '0 : man_a >> diff;
      end
   end

   // Add/subtract magnitudes, normalise, then flush or saturate.
   always_comb begin
      if (sa_q == sb_q) begin
         mag = {1'b0, ma_q} + {1'b0, mb_q};
         sgn = sa_q;
      end else if (ma_q >= mb_q) begin
         mag = {1'b0, ma_q - mb_q};
         sgn = sa_q;
      end else begin
         mag = {1'b0, mb_q - ma_q};
         sgn = sb_q;
      end
      lz = '0;
      for (int unsigned i = 0; i < 10; i++)
         if (mag[i]) lz = 4'(9 - i);
      if (mag[10]) begin
         nm = mag[10:1];
         ne = $signed({2'b00, exp_q}) + 7'sd1;
      end else begin
         nm = mag[9:0] << lz;
         ne = $signed({2'b00, exp_q}) - $signed({3'b000, lz});
      end
`ifdef FP12_ACC_STICKY_FLAGS_EN
      ovf_w = 1'b0;
      unf_w = 1'b0;
`endif
      if (mag == '0) begin
         res = '0;
      end else if (ne <= 7'sd0) begin
         res = '0;
`ifdef FP12_ACC_STICKY_FLAGS_EN
         unf_w = 1'b1;
`endif
      end else if (ne >= 7'sd30) begin
         res = {sgn, 5'd30, 6'b110000};
`ifdef FP12_ACC_STICKY_FLAGS_EN
         ovf_w = 1'b1;
`endif
      end else begin
         res = {sgn, ne[4:0], 6'(nm >> 3)};
      end
   end

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCEPT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCEPT: if (acc_if.in_valid) state_d = ALIGN;
         ALIGN:  state_d = NORM;
         NORM:   state_d = last_q ? HOLD : ACCEPT;
         HOLD:   if (acc_if.sum_ready) state_d = ACCEPT;
         default: state_d = ACCEPT;
      endcase
   end

   always_comb begin
      acc_if.in_ready  = (state_q == ACCEPT);
      acc_if.sum_valid = (state_q == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_q      <= '0;
         last_q      <= 1'b0;
         acc_q       <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         ma_q        <= '0;
         mb_q        <= '0;
         exp_q       <= '0;
         cnt_q       <= '0;
         sum_data_q  <= '0;
         sum_count_q <= '0;
`ifdef FP12_ACC_STICKY_FLAGS_EN
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ACCEPT: if (acc_if.in_valid) begin
               term_q <= acc_if.in_data;
               last_q <= acc_if.in_last;
            end
            ALIGN: begin
               sa_q  <= acc_q[11];
               sb_q  <= term_q[11];
               ma_q  <= al_a;
               mb_q  <= al_b;
               exp_q <= big_exp;
            end
            NORM: begin
               acc_q <= res;
               cnt_q <= cnt_inc;
`ifdef FP12_ACC_STICKY_FLAGS_EN
               ovf_q <= ovf_q | ovf_w;
               unf_q <= unf_q | unf_w;
`endif
               if (last_q) begin
                  sum_data_q  <= res;
                  sum_count_q <= cnt_inc;
               end
            end
            HOLD: if (acc_if.sum_ready) begin
               acc_q <= '0;
               cnt_q <= '0;
`ifdef FP12_ACC_STICKY_FLAGS_EN
               ovf_q <= 1'b0;
               unf_q <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign acc_if.sum_data  = sum_data_q;
   assign acc_if.sum_count = sum_count_q;
`ifdef FP12_ACC_STICKY_FLAGS_EN
   assign acc_if.sum_flags = {ovf_q, unf_q};
`endif
endmodule

// File: tb/tb_fp12_accumulator.sv
// Directed + randomised bench for fp12_accumulator with a queue scoreboard.
// Checks sum_flags as well when FP12_ACC_STICKY_FLAGS_EN is defined.
module tb_fp12_accumulator;
   localparam int DROP = 10;

   typedef struct packed {
      logic [11:0] d;
      logic [7:0]  c;
      logic [1:0]  f;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   logic [11:0] m_acc;
   int          m_cnt;
   bit          m_ovf, m_unf;

   fp12_acc_if #(.CNT_W(8)) bus ();

   fp12_accumulator #(.CNT_W(8), .ALIGN_DROP(10)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .acc_if (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Independent integer reference of the truncating add.
   function automatic logic [11:0] m_add(input logic [11:0] a, input logic [11:0] b,
                                         output bit ovf, output bit unf);
      int ea, eb, ma, mb, e, s, mag;
      bit neg;
      ovf = 0;
      unf = 0;
      ea = int'(a[10:6]);
      eb = int'(b[10:6]);
      ma = (ea != 0) ? (64 + int'(a[5:0])) * 8 : 0;
      mb = (eb != 0) ? (64 + int'(b[5:0])) * 8 : 0;
      if (ea >= eb) begin
         e  = ea;
         mb = (ea - eb >= DROP) ? 0 : mb >> (ea - eb);
      end else begin
         e  = eb;
         ma = (eb - ea >= DROP) ? 0 : ma >> (eb - ea);
      end
      s = (a[11] ? -ma : ma) + (b[11] ? -mb : mb);
      if (s == 0) return 12'h000;
      neg = (s < 0);
      mag = neg ? -s : s;
      while (mag >= 1024) begin mag = mag / 2; e++; end
      while (mag < 512)   begin mag = mag * 2; e--; end
      if (e <= 0) begin unf = 1; return 12'h000; end
      if (e >= 30) begin ovf = 1; return {neg, 5'd30, 6'b110000}; end
      return {neg, 5'(e), 6'((mag / 8) % 64)};
   endfunction

   task automatic model_clear();
      m_acc = '0;
      m_cnt = 0;
      m_ovf = 0;
      m_unf = 0;
   endtask

   task automatic send(input logic [11:0] d, input bit last, input int unsigned gap);
      bit o, u;
      int unsigned w;
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      w = 0;
      while (!bus.in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      m_acc = m_add(m_acc, d, o, u);
      m_ovf = m_ovf | o;
      m_unf = m_unf | u;
      if (m_cnt < 255) m_cnt++;
      if (last) begin
         sb.push_back('{d: m_acc, c: 8'(m_cnt), f: {m_ovf, m_unf}});
         model_clear();
      end
   endtask

   task automatic take_sum(input int unsigned stall);
      int unsigned w;
      exp_t e;
      w = 0;
      while (!bus.sum_valid && w < 50) begin tick(); w++; end
      if (w >= 50) begin
         check("sum_valid_timeout", 32'(bus.sum_valid), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check("sb_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check("sum_data", 32'(bus.sum_data), 32'(e.d));
      check("sum_count", 32'(bus.sum_count), 32'(e.c));
`ifdef FP12_ACC_STICKY_FLAGS_EN
      check("sum_flags", 32'(bus.sum_flags), 32'(e.f));
`endif
      repeat (stall) begin
         tick();
         check("hold_stable", {10'd0, bus.sum_valid, bus.in_ready, bus.sum_data, bus.sum_count},
               {10'd0, 1'b1, 1'b0, e.d, e.c});
      end
      bus.sum_ready = 1'b1;
      tick();
      bus.sum_ready = 1'b0;
      check("sum_valid_drop", 32'(bus.sum_valid), 32'd0);
   endtask

   initial begin
      logic [11:0] d;
      int unsigned n;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.sum_ready = 1'b0;
      model_clear();
      repeat (3) tick();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
      check("rst_sum_data", 32'(bus.sum_data), 32'h000);
      check("rst_sum_count", 32'(bus.sum_count), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single term: latency and in_ready low through ALIGN/NORM/HOLD.
      send(12'h3C0, 1'b1, 0);
      check("lat_align", {30'd0, bus.in_ready, bus.sum_valid}, 32'd0);
      tick();
      check("lat_norm", {30'd0, bus.in_ready, bus.sum_valid}, 32'd0);
      tick();
      check("lat_hold", {30'd0, bus.in_ready, bus.sum_valid}, 32'd1);
      check("one_term_data", 32'(bus.sum_data), 32'h3C0);
      take_sum(0);

      // 1+1+1 = 3.0 held under backpressure, then 1.5 + 0.5.
      send(12'h3C0, 1'b0, 0);
      send(12'h3C0, 1'b0, 0);
      send(12'h3C0, 1'b1, 0);
      take_sum(5);
      send(12'h3E0, 1'b0, 0);
      send(12'h380, 1'b1, 0);
      take_sum(0);

      // Cancellation, dropped small operand, saturation both signs.
      send(12'h3C0, 1'b0, 0);
      send(12'hBC0, 1'b1, 0);
      take_sum(0);
      send(12'h3C0, 1'b0, 0);
      send(12'h100, 1'b1, 1);
      take_sum(0);
      send(12'h740, 1'b0, 0);
      send(12'h740, 1'b1, 0);
      take_sum(0);
      send(12'hF40, 1'b0, 0);
      send(12'hF40, 1'b1, 0);
      take_sum(1);

      // Reset during ALIGN of the second term discards the partial sum.
      send(12'h3C0, 1'b0, 0);
      tick();
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 12'h3C0;
      bus.in_last  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      rst_n = 1'b0;
      model_clear();
      tick();
      check("rst_mid_state", {20'd0, bus.in_ready, bus.sum_valid, bus.sum_count, 2'b00},
            {20'd0, 1'b1, 1'b0, 8'd0, 2'b00});
      rst_n = 1'b1;
      repeat (4) tick();
      check("rst_mid_no_sum", 32'(bus.sum_valid), 32'd0);
      send(12'h400, 1'b1, 0);
      take_sum(0);

      // Randomised terms and backpressure.
      for (int s = 0; s < 200; s++) begin
         n = $urandom_range(1, 5);
         for (int unsigned t = 0; t < n; t++) begin
            d = 12'($urandom);
            if ($urandom_range(0, 7) != 0) d[10:6] = 5'($urandom_range(8, 24));
            send(d, t == n - 1, $urandom_range(0, 2));
         end
         take_sum($urandom_range(0, 3));
      end

      // Term counter saturation.
      for (int i = 0; i < 300; i++) send(12'h000, i == 299, 0);
      check("sat_model_count", 32'(sb[0].c), 32'd255);
      take_sum(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule
